rr_arbiter_n: RTL and testbench

Parametrised N-channel round-robin arbiter with registered one-hot grant, grant hold while the owner keeps requesting, and a bounded hold time that forces rotation when other channels wait. It replaces the free-running 3-channel rotating arbiter. The rotation pointer advances only on actual grants, so idle channels never waste a slot. It sits in front of any shared single-port resource: bus, memory port or output FIFO.

---
 rtl/rr_arb_pkg.sv | 22 ++
 rtl/rr_arbiter_n_if.sv | 15 +
 rtl/rr_pick.sv | 27 ++
 rtl/rr_arbiter_n.sv | 104 ++++++++++
 tb/tb_rr_arbiter_n.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter and its picker.
package rr_arb_pkg;

    localparam int RR_MAX_N   = 32;
    localparam int RR_MAX_IDW = $clog2(RR_MAX_N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_e;

    // OR-based encoder: exact for one-hot input, zero for an all-zero input.
    function automatic logic [RR_MAX_IDW-1:0] onehot_to_bin(input logic [RR_MAX_N-1:0] oh);
        logic [RR_MAX_IDW-1:0] bin;
        bin = '0;
        for (int i = 0; i < RR_MAX_N; i++) begin
            if (oh[i]) bin = bin | RR_MAX_IDW'(i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
interface rr_arbiter_n_if #(
    parameter int N = 4
) ();
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;

    modport master (output req, input gnt, input gnt_id, input gnt_valid);
    modport slave  (input req, output gnt, output gnt_id, output gnt_valid);

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit of cand searching from ptr+1 circularly.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   cand,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   win,
    output logic [IDW-1:0] win_id,
    output logic           any
);

    logic [IDW:0] shamt;
    logic [N-1:0] rot;
    logic [N-1:0] rot_win;

    // Rotate so bit 0 is channel ptr+1, isolate the lowest set bit, then rotate back.
    assign shamt   = {1'b0, ptr} + (IDW+1)'(1);
    assign rot     = N'({cand, cand} >> shamt);
    assign rot_win = rot & (~rot + N'(1));
    assign win     = N'({rot_win, rot_win} << shamt >> N);
    assign win_id  = IDW'(onehot_to_bin(RR_MAX_N'(win)));
    assign any     = |cand;

endmodule

// File: rtl/rr_arbiter_n.sv
// N-channel round-robin arbiter with registered one-hot grant, grant hold and bounded hold time.
module rr_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 4,
    parameter int IDW      = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter_n_if.slave    bus
);

    localparam int HCW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    rr_state_e      state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           gnt_valid_q;

    logic [N-1:0]   owner_oh;
    logic [N-1:0]   others;
    logic [N-1:0]   cand;
    logic [N-1:0]   win;
    logic [IDW-1:0] win_id;
    logic           any;
    logic           force_rel;

    assign owner_oh  = N'(1) << ptr_q;
    assign others    = bus.req & ~owner_oh;
    assign cand      = (state_q == IDLE) ? bus.req : others;
    assign force_rel = (HOLD_MAX != 0) && (hold_q == HCW'(HOLD_MAX)) && (|others);

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .cand   (cand),
        .ptr    (ptr_q),
        .win    (win),
        .win_id (win_id),
        .any    (any)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (any) begin
                    state_d  = GRANT;
                    ptr_d    = win_id;
                    hold_d   = HCW'(1);
                    gnt_d    = win;
                    gnt_id_d = win_id;
                end
            end
            GRANT: begin
                if (bus.req[ptr_q] && !force_rel) begin
                    if (HOLD_MAX != 0 && hold_q != HCW'(HOLD_MAX)) hold_d = hold_q + HCW'(1);
                end else if (any) begin
                    // Back-to-back handover: old bit falls and new bit rises at the same edge.
                    ptr_d    = win_id;
                    hold_d   = HCW'(1);
                    gnt_d    = win;
                    gnt_id_d = win_id;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(N - 1);
            hold_q      <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= |gnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed and random bench for rr_arbiter_n with a reference model feeding a scoreboard queue.
module tb_rr_arbiter_n;
    import rr_arb_pkg::*;

    localparam int N        = 4;
    localparam int HOLD_MAX = 4;
    localparam int IDW      = $clog2(N);
    localparam int MAX_WAIT = (N - 1) * HOLD_MAX + 1;

    typedef struct packed {
        logic [N-1:0]   gnt;
        logic [IDW-1:0] id;
        logic           valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_arbiter_n_if #(.N(N)) bus ();

    rr_arbiter_n #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t      sb_q[$];
    int        n_checks = 0;
    int        n_err    = 0;

    rr_state_e    m_state;
    int           m_ptr;
    int           m_hold;
    logic [N-1:0] m_gnt;
    int           m_id;
    int           wait_cnt[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] c, input int p);
        for (int d = 1; d <= N; d++) begin
            if (c[(p + d) % N]) return (p + d) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = IDLE;
        m_ptr   = N - 1;
        m_hold  = 0;
        m_gnt   = '0;
        m_id    = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        sb_q.delete();
    endtask

    task automatic model_grant(input int w);
        m_state  = GRANT;
        m_ptr    = w;
        m_id     = w;
        m_hold   = 1;
        m_gnt    = '0;
        m_gnt[w] = 1'b1;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        logic [N-1:0] oth;
        int           w;
        exp_t         e;
        if (m_state == IDLE) begin
            w = pick(r, m_ptr);
            if (w >= 0) model_grant(w);
            else        m_gnt = '0;
        end else begin
            oth        = r;
            oth[m_ptr] = 1'b0;
            if (r[m_ptr] && !(m_hold >= HOLD_MAX && oth != '0)) begin
                if (m_hold < HOLD_MAX) m_hold++;
            end else if (oth != '0) begin
                model_grant(pick(oth, m_ptr));
            end else begin
                m_state = IDLE;
                m_gnt   = '0;
            end
        end
        e.gnt   = m_gnt;
        e.id    = IDW'(m_id);
        e.valid = (m_gnt != '0);
        sb_q.push_back(e);
    endtask

    // One clock: drive req, predict, then compare just after the edge.
    task automatic cycle(input logic [N-1:0] r, input string tag);
        exp_t e;
        bus.req = r;
        model_step(r);
        @(posedge clk);
        #1;
        check({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_gnt"},       bus.gnt,       e.gnt);
            check({tag, "_gnt_valid"}, bus.gnt_valid, e.valid);
            check({tag, "_gnt_id"},    bus.gnt_id,    e.id);
        end
        check({tag, "_onehot"}, $countones(bus.gnt) <= 1, 1);
        check({tag, "_gnt_follows_req"}, (bus.gnt & ~r) == '0, 1);
        if (bus.gnt_valid) check({tag, "_id_matches_gnt"}, bus.gnt[bus.gnt_id], 1);
        for (int i = 0; i < N; i++) begin
            if (r[i] && !bus.gnt[i]) wait_cnt[i]++;
            else                     wait_cnt[i] = 0;
            check({tag, "_wait_bound"}, wait_cnt[i] <= MAX_WAIT, 1);
        end
    endtask

    initial begin
        logic [N-1:0] r;
        bus.req = '0;
        rst_n   = 1'b0;
        model_reset();
        #12;
        check("reset_gnt",       bus.gnt,       0);
        check("reset_gnt_valid", bus.gnt_valid, 0);
        check("reset_gnt_id",    bus.gnt_id,    0);
        check("reset_state",     32'(dut.state_q), 32'(IDLE));
        check("reset_ptr",       dut.ptr_q,     N - 1);
        check("reset_hold",      dut.hold_q,    0);
        @(negedge clk);
        rst_n = 1'b1;

        // All channels requesting: 0,1,2,3,0, four cycles each, no gaps.
        for (int c = 0; c < 20; c++) begin
            cycle(4'b1111, "t1");
            check("t1_owner", bus.gnt_id, (c / 4) % 4);
            check("t1_no_gap", bus.gnt_valid, 1);
        end

        // Lone requester is never preempted.
        for (int c = 0; c < 10; c++) begin
            cycle(4'b0100, "t2");
            check("t2_hold", bus.gnt, 4'b0100);
        end
        cycle(4'b0000, "t2_drop");
        check("t2_released", bus.gnt, 0);
        check("t2_idle", 32'(dut.state_q), 32'(IDLE));

        // From ptr=2, req=1011 serves 3, then 0, then 1.
        for (int c = 0; c < 12; c++) begin
            cycle(4'b1011, "t4");
            check("t4_owner", bus.gnt_id, (c < 4) ? 3 : (c < 8) ? 0 : 1);
        end
        cycle(4'b0000, "t4_drop");

        // Owner 1 drops while 3 waits: zero-gap handover.
        cycle(4'b0010, "t3");
        check("t3_first", bus.gnt, 4'b0010);
        cycle(4'b1010, "t3");
        check("t3_hold", bus.gnt, 4'b0010);
        cycle(4'b1000, "t3");
        check("t3_handover", bus.gnt, 4'b1000);

        // Asynchronous reset while channel 3 owns the grant.
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt",   bus.gnt,       0);
        check("t5_async_valid", bus.gnt_valid, 0);
        check("t5_async_id",    bus.gnt_id,    0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1010, "t5");
        check("t5_post_reset", bus.gnt, 4'b0010);

        // Random requests with persistence: each bit toggles with probability 1/4.
        r = bus.req;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) r[i] = ~r[i];
            end
            cycle(r, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
